// File: rtl/adder_pkg.sv
// Shared definitions for the sequential multi-word adder.
//   WORD_W       : width of one adder slice
//   add_state_t  : sequencer states
//   slice_idx_w  : width of the slice index counter for a given word count
package adder_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } add_state_t;

  // Never returns zero, so a 1-wide counter still exists for tiny word counts.
  function automatic int slice_idx_w(input int words);
    return (words <= 2) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/multiword_add_seq_adder.sv
// AheadAdder16bit_module: 16-bit two-level carry-lookahead adder.
//   a, b : addends
//   c0   : carry in
//   f    : sum
//   c    : carry out of bit 15
// Four 4-bit groups generate group G/P; group carries are fully expanded
// from c0, then each group resolves its internal carries from its group carry.
module AheadAdder16bit_module (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c0,
  output logic [15:0] f,
  output logic        c
);

  logic [15:0] g, p, ci;
  logic [3:0]  gg, gp;
  logic [4:0]  gc;

  assign g = a & b;
  assign p = a ^ b;

  for (genvar k = 0; k < 4; k++) begin : g_grp
    assign gg[k] = g[4*k+3]
                 | (p[4*k+3] & g[4*k+2])
                 | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                 | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    assign gp[k] = &p[4*k +: 4];

    assign ci[4*k]   = gc[k];
    assign ci[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
    assign ci[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & gc[k]);
    assign ci[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
  end

  assign gc[0] = c0;
  assign gc[1] = gg[0] | (gp[0] & c0);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c0);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & c0);
  assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0])
               | (gp[3] & gp[2] & gp[1] & gp[0] & c0);

  assign f = p ^ ci;
  assign c = gc[4];

endmodule

// File: rtl/multiword_add_seq.sv
// multiword_add_seq: wide add/subtract by iterating one 16-bit lookahead
// adder over WORDS slices, LSB slice first, carry registered between slices.
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : operand handshake (a, b, cin, sub)
//   out_valid/out_ready : result handshake (sum, cout, ovf)
//   sub=1 computes a + ~b + 1 (cin ignored); cout=1 then means no borrow.
module multiword_add_seq
  import adder_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_W*WORDS-1:0] a,
  input  logic [WORD_W*WORDS-1:0] b,
  input  logic                    cin,
  input  logic                    sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORD_W*WORDS-1:0] sum,
  output logic                    cout,
  output logic                    ovf
);

  localparam int W  = WORD_W * WORDS;
  localparam int IW = slice_idx_w(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  add_state_t state, nxt;

  logic [W-1:0]      a_reg, b_reg;
  logic              a_msb, b_msb;
  logic              carry_reg;
  logic [IW-1:0]     idx;
  logic [WORD_W-1:0] a_sl, b_sl, f_sl;
  logic              c_sl;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Slice mux: the only logic in front of the adder.
  assign a_sl = a_reg[idx*WORD_W +: WORD_W];
  assign b_sl = b_reg[idx*WORD_W +: WORD_W];

  AheadAdder16bit_module u_add (
    .a  (a_sl),
    .b  (b_sl),
    .c0 (carry_reg),
    .f  (f_sl),
    .c  (c_sl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (in_valid)     nxt = RUN;
      RUN:     if (idx == LAST)  nxt = DONE;
      DONE:    if (out_ready)    nxt = IDLE;
      default:                   nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
      carry_reg <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_reg     <= a;
          b_reg     <= sub ? ~b : b;
          a_msb     <= a[W-1];
          b_msb     <= sub ? ~b[W-1] : b[W-1];
          carry_reg <= sub ? 1'b1 : cin;
          idx       <= '0;
          sum       <= '0;
        end
        RUN: begin
          sum[idx*WORD_W +: WORD_W] <= f_sl;
          carry_reg <= c_sl;
          if (idx == LAST) begin
            idx  <= '0;
            cout <= c_sl;
            // Same-sign operands producing an opposite-sign result.
            ovf  <= (a_msb == b_msb) && (f_sl[WORD_W-1] != a_msb);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiword_add_seq.sv
module tb_multiword_add_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [63:0] a, b, sum;
  logic        cin, sub, cout, ovf;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multiword_add_seq #(.WORDS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request, check latency and result; optionally complete hand-off.
  task automatic run_op(input string tag, input logic [63:0] ta, input logic [63:0] tb_,
                        input logic tcin, input logic tsub, input logic [63:0] esum,
                        input logic ecout, input logic eovf, input bit release_out);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk({tag, "_rdy_wait"}, 64'(in_ready), 64'd1);
    a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk({tag, "_lat"}, 64'(n), 64'd4);
    chk({tag, "_sum"}, sum, esum);
    chk({tag, "_cout"}, 64'(cout), 64'(ecout));
    chk({tag, "_ovf"}, 64'(ovf), 64'(eovf));
    if (release_out) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_vld_drop"}, 64'(out_valid), 64'd0);
      chk({tag, "_rdy_back"}, 64'(in_ready), 64'd1);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", sum, 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Carry out of slice 0 into slice 1.
    run_op("s2", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
           64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1);
    run_op("s3", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
           64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1);
    run_op("s4", 64'h5, 64'h7, 1'b1, 1'b1,
           64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1);
    // Subtract without borrow: 0x10000 - 1.
    run_op("sub_nb", 64'h1_0000, 64'h1, 1'b0, 1'b1,
           64'h0_FFFF, 1'b1, 1'b0, 1'b1);

    // Scenario 1 then backpressure with in_valid pulses.
    run_op("s1", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0,
           64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      a = 64'h1234_5678_9ABC_DEF0 + 64'(i); b = 64'h1111; cin = 1'b1;
      @(posedge clk); #1;
      chk("bp_sum", sum, 64'h0000_0000_0001_0000);
      chk("bp_flags", {62'd0, cout, ovf}, 64'd0);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_vld", 64'(out_valid), 64'd0);
    chk("bp_release_rdy", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    chk("bp_no_capture", 64'(in_ready), 64'd1);

    // Reset two cycles into RUN.
    a = 64'h1111_1111_1111_1111; b = 64'h2222_2222_2222_2222; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_sum", sum, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("post_rst", 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b1, 1'b0,
           64'h3333_3333_3333_3334, 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
